// File: rtl/life_pkg.sv
// Shared types and constants for the Game of Life engine and its neighbour counter.
package life_pkg;

    localparam logic [2:0] COL_ALIVE = 3'b111;
    localparam logic [2:0] COL_DEAD  = 3'b000;
    localparam int         CNT_W     = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SCAN,
        COMMIT,
        CLEAR
    } state_t;

endpackage

// File: rtl/life_neighbour_count.sv
// Live-neighbour count (0..8) of one cell in a flattened row-major grid,
// with either dead borders or toroidal wrap.
module life_neighbour_count
    import life_pkg::*;
#(
    parameter int W    = 16,
    parameter int H    = 16,
    parameter int WRAP = 0
) (
    input  logic [W*H-1:0]   cells,
    input  logic [7:0]       row,
    input  logic [7:0]       col,
    output logic [CNT_W-1:0] count
);

    localparam int IW = $clog2(W * H);

    always_comb begin
        int r;
        int c;
        logic [IW-1:0] idx;
        r     = 0;
        c     = 0;
        idx   = '0;
        count = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                r = int'(row) + dr;
                c = int'(col) + dc;
                if (WRAP != 0) begin
                    if (r < 0) r = H - 1; else if (r >= H) r = 0;
                    if (c < 0) c = W - 1; else if (c >= W) c = 0;
                end
                idx = IW'(r * W + c);
                // Off-grid positions only survive here when wrap is disabled; they count as dead.
                if (!(dr == 0 && dc == 0) && r >= 0 && r < H && c >= 0 && c < W)
                    count = count + CNT_W'(cells[idx]);
            end
        end
    end

endmodule

// File: rtl/life_engine.sv
// Double-buffered Game of Life engine: one generation per step, streaming a
// plot command through a single-entry valid/ready register for every changed cell.
module life_engine
    import life_pkg::*;
#(
    parameter int W     = 16,
    parameter int H     = 16,
    parameter int WRAP  = 0,
    parameter int X_OFF = 0,
    parameter int Y_OFF = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load_valid,
    input  logic [7:0]  load_x,
    input  logic [7:0]  load_y,
    input  logic        load_alive,
    output logic        load_ready,
    input  logic        step,
    input  logic        clear,
    output logic        plot_valid,
    input  logic        plot_ready,
    output logic [7:0]  plot_x,
    output logic [7:0]  plot_y,
    output logic [2:0]  plot_colour,
    output logic        busy,
    output logic [15:0] gen_count
);

    localparam int         N      = W * H;
    localparam int         IW     = $clog2(N);
    localparam logic [7:0] W8     = 8'(W);
    localparam logic [7:0] H8     = 8'(H);
    localparam logic [7:0] W_LAST = 8'(W - 1);
    localparam logic [7:0] H_LAST = 8'(H - 1);
    localparam logic [7:0] XO     = 8'(X_OFF);
    localparam logic [7:0] YO     = 8'(Y_OFF);

    state_t state, state_d;
    logic [N-1:0]     cur, nxt;
    logic [7:0]       row, col;
    logic [IW-1:0]    cidx, lidx;
    logic [CNT_W-1:0] ncount;
    logic             alive, next_alive, adv, last, load_fire, load_in_range;
    logic             plot_load;
    logic [7:0]       px_d, py_d;
    logic [2:0]       pc_d;

    life_neighbour_count #(.W(W), .H(H), .WRAP(WRAP)) u_count (
        .cells (cur),
        .row   (row),
        .col   (col),
        .count (ncount)
    );

    assign cidx          = IW'(row * W + col);
    assign lidx          = IW'(load_y * W + load_x);
    assign alive         = cur[cidx];
    assign next_alive    = (ncount == 4'd3) | (alive & (ncount == 4'd2));
    assign load_in_range = (load_x < W8) && (load_y < H8);
    assign busy          = (state != IDLE);

    always_comb begin
        state_d    = state;
        plot_load  = 1'b0;
        load_fire  = 1'b0;
        px_d       = XO + col;
        py_d       = YO + row;
        pc_d       = COL_DEAD;
        adv        = !plot_valid || plot_ready;
        last       = (row == H_LAST) && (col == W_LAST);
        load_ready = (state == IDLE) && !plot_valid;
        case (state)
            IDLE: begin
                if (!plot_valid) begin
                    if (clear) begin
                        state_d = CLEAR;
                    end else if (step) begin
                        state_d = SCAN;
                    end else if (load_valid) begin
                        state_d   = LOAD;
                        load_fire = 1'b1;
                        if (load_in_range && (load_alive != cur[lidx])) begin
                            plot_load = 1'b1;
                            px_d      = XO + load_x;
                            py_d      = YO + load_y;
                            pc_d      = load_alive ? COL_ALIVE : COL_DEAD;
                        end
                    end
                end
            end
            LOAD:   state_d = IDLE;
            SCAN: begin
                if (adv) begin
                    if (next_alive != alive) begin
                        plot_load = 1'b1;
                        pc_d      = next_alive ? COL_ALIVE : COL_DEAD;
                    end
                    if (last) state_d = COMMIT;
                end
            end
            COMMIT: state_d = IDLE;
            CLEAR: begin
                if (adv) begin
                    plot_load = alive;
                    if (last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cur         <= '0;
            nxt         <= '0;
            row         <= '0;
            col         <= '0;
            gen_count   <= '0;
            plot_valid  <= 1'b0;
            plot_x      <= '0;
            plot_y      <= '0;
            plot_colour <= '0;
        end else begin
            if (load_fire && load_in_range) begin
                cur[lidx] <= load_alive;
                nxt[lidx] <= load_alive;
            end
            // Evaluation reads only cur; results land in nxt until COMMIT swaps them in.
            if (state == SCAN && adv) nxt[cidx] <= next_alive;
            if (state == CLEAR && adv) begin
                cur[cidx] <= 1'b0;
                nxt[cidx] <= 1'b0;
            end
            if (state == COMMIT) begin
                cur       <= nxt;
                gen_count <= gen_count + 16'd1;
            end
            if ((state == SCAN || state == CLEAR) && adv) begin
                if (col == W_LAST) begin
                    col <= '0;
                    row <= last ? 8'd0 : row + 8'd1;
                end else begin
                    col <= col + 8'd1;
                end
            end
            if (plot_load) begin
                plot_valid  <= 1'b1;
                plot_x      <= px_d;
                plot_y      <= py_d;
                plot_colour <= pc_d;
            end else if (plot_ready) begin
                plot_valid  <= 1'b0;
            end
        end
    end

endmodule
